// File: rtl/vpu_op_timer.sv
// Bank of independent delay timers. Each channel counts a latched delay and
// pulses done_o on expiry, once (one-shot) or repeatedly (periodic).
module vpu_op_timer #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       start_i,
    input  logic [NUM_CH*CNT_W-1:0] count_i,
    input  logic [NUM_CH-1:0]       mode_i,
    input  logic [NUM_CH-1:0]       abort_i,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH-1:0]       done_o,
    output logic [NUM_CH-1:0]       err_o,
    output logic                    any_done_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W-1:0] dly_q, dly_d;
            logic             mode_q, mode_d;
            logic             done_q, done_d;
            logic             err_q, err_d;
            logic [CNT_W-1:0] cnt_in;
            logic             req;

            // cnt_q holds the cycles left until the next done pulse; a stored
            // zero stands for 2^CNT_W and wraps naturally on decrement.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                dly_d   = dly_q;
                mode_d  = mode_q;
                done_d  = 1'b0;
                err_d   = 1'b0;
                cnt_in  = count_i[gi*CNT_W +: CNT_W];
                req     = start_i[gi] && !abort_i[gi];

                if (req && state_q == ST_IDLE) begin
                    dly_d  = cnt_in;
                    mode_d = mode_i[gi];
                    if (cnt_in == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        cnt_d   = cnt_in;
                        state_d = mode_i[gi] ? ST_RUN : ST_IDLE;
                    end else begin
                        cnt_d   = cnt_in - CNT_W'(1);
                        state_d = ST_RUN;
                    end
                end else if (state_q == ST_RUN) begin
                    err_d = req;
                    if (abort_i[gi]) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == CNT_W'(1)) begin
                        done_d = 1'b1;
                        if (mode_q) begin
                            cnt_d = dly_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    dly_q   <= '0;
                    mode_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    dly_q   <= dly_d;
                    mode_q  <= mode_d;
                    done_q  <= done_d;
                    err_q   <= err_d;
                end
            end

            assign busy_o[gi] = (state_q == ST_RUN);
            assign done_o[gi] = done_q;
            assign err_o[gi]  = err_q;
        end
    endgenerate

    assign any_done_o = |done_o;

endmodule

// File: tb/tb_vpu_op_timer.sv
// Directed bench for vpu_op_timer (4 channels, 4-bit counts); expected
// per-cycle output vectors are written out by hand for each scenario.
module tb_vpu_op_timer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  start_i;
    logic [15:0] count_i;
    logic [3:0]  mode_i;
    logic [3:0]  abort_i;
    logic [3:0]  busy_o;
    logic [3:0]  done_o;
    logic [3:0]  err_o;
    logic        any_done_o;

    int n_vec;
    int n_mis;

    vpu_op_timer #(.NUM_CH(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .count_i    (count_i),
        .mode_i     (mode_i),
        .abort_i    (abort_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .any_done_o (any_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        start_i = '0;
        abort_i = '0;
        mode_i  = '0;
        count_i = '0;
    endtask

    task automatic check_all(input string tag, input int cyc, input logic [3:0] e_busy,
                             input logic [3:0] e_done, input logic [3:0] e_err);
        chk({tag, "_busy"}, cyc, {28'd0, busy_o}, {28'd0, e_busy});
        chk({tag, "_done"}, cyc, {28'd0, done_o}, {28'd0, e_done});
        chk({tag, "_err"},  cyc, {28'd0, err_o},  {28'd0, e_err});
        chk({tag, "_any"},  cyc, {31'd0, any_done_o}, {31'd0, |e_done});
    endtask

    // Leaves the bench 1 time unit after the edge that opens cycle 0.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all("reset", 0, 4'h0, 4'h0, 4'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_mis = 0;

        // One-shot delays: 5 on ch0, 0 (=16) on ch1, 1 on ch2.
        do_reset();
        for (int c = 0; c <= 18; c++) begin
            logic [3:0] eb, ed;
            clear_inputs();
            if (c == 0) begin
                start_i[1] = 1'b1; count_i[7:4] = 4'd0;
                start_i[2] = 1'b1; count_i[11:8] = 4'd1;
            end
            if (c == 10) begin
                start_i[0] = 1'b1; count_i[3:0] = 4'd5;
            end
            @(negedge clk);
            eb = {1'b0, 1'b0, (c >= 1 && c <= 15), (c >= 11 && c <= 14)};
            ed = {1'b0, (c == 1), (c == 16), (c == 15)};
            check_all("oneshot", c, eb, ed, 4'h0);
            $display("oneshot cyc=%0d busy=%b done=%b err=%b", c, busy_o, done_o, err_o);
            @(posedge clk);
            #1;
        end

        // Periodic, rejects, abort, start+abort, restart in done cycle.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            logic [3:0] eb, ed, ee;
            clear_inputs();
            case (c)
                0: begin
                    start_i = 4'b1111; abort_i[2] = 1'b1;
                    mode_i  = 4'b0011;
                    count_i = {4'd4, 4'd2, 4'd1, 4'd3};
                end
                2: begin start_i[3] = 1'b1; count_i[15:12] = 4'd7; end
                3: begin start_i[0] = 1'b1; abort_i[2] = 1'b1; end
                4: begin start_i[3] = 1'b1; count_i[15:12] = 4'd2; end
                5: abort_i[1] = 1'b1;
                7: abort_i[0] = 1'b1;
                8: begin start_i[2] = 1'b1; count_i[11:8] = 4'd2; end
                default: ;
            endcase
            @(negedge clk);
            eb = {((c >= 1 && c <= 3) || c == 5), (c == 9), (c >= 1 && c <= 5),
                  (c >= 1 && c <= 7)};
            ed = {(c == 4 || c == 6), (c == 10), (c >= 1 && c <= 5),
                  (c == 3 || c == 6)};
            ee = {(c == 3), 1'b0, 1'b0, (c == 4)};
            check_all("mixed", c, eb, ed, ee);
            $display("mixed cyc=%0d busy=%b done=%b err=%b", c, busy_o, done_o, err_o);
            @(posedge clk);
            #1;
        end

        // Reset mid-run cancels both timers; start during reset ignored.
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            logic [3:0] eb;
            clear_inputs();
            rst_n = (c != 1);
            if (c == 0) begin
                start_i = 4'b0011; count_i = {4'd0, 4'd0, 4'd3, 4'd3};
            end
            if (c == 1) begin
                start_i[2] = 1'b1; count_i[11:8] = 4'd2;
            end
            @(negedge clk);
            eb = (c == 1) ? 4'b0011 : 4'b0000;
            check_all("rstmid", c, eb, 4'h0, 4'h0);
            $display("rstmid cyc=%0d busy=%b done=%b err=%b", c, busy_o, done_o, err_o);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        // Periodic with count 0 (period 16) on ch3, aborted in cycle 33.
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            logic [3:0] eb, ed;
            clear_inputs();
            if (c == 0) begin
                start_i[3] = 1'b1; mode_i[3] = 1'b1; count_i[15:12] = 4'd0;
            end
            if (c == 33) abort_i[3] = 1'b1;
            @(negedge clk);
            eb = {(c >= 1 && c <= 33), 3'b000};
            ed = {(c == 16 || c == 32), 3'b000};
            check_all("per16", c, eb, ed, 4'h0);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/vpu_op_timer.md
VPU_OP_TIMER -- requirements
Module: vpu_op_timer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent timer channels (1..16).
REQ-002 Parameter CNT_W, default 4: width of each channel's delay count (2..16).
REQ-003 The block SHALL provide the following ports, one per line.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start_i  in  NUM_CH  per-channel start request, sampled each rising edge.
REQ-007 count_i  in  NUM_CH*CNT_W  per-channel delay; channel c uses bits [c*CNT_W +: CNT_W]; sampled only with an accepted start.
REQ-008 mode_i  in  NUM_CH  per-channel mode: 0 = one-shot, 1 = periodic; sampled only with an accepted start.
REQ-009 abort_i  in  NUM_CH  per-channel abort of a running timer.
REQ-010 busy_o  out  NUM_CH  channel is counting.
REQ-011 done_o  out  NUM_CH  one-cycle pulse when the channel delay expires.
REQ-012 err_o  out  NUM_CH  one-cycle pulse when a start is rejected.
REQ-013 any_done_o  out  1  OR of all done_o bits in the same cycle.

Function
REQ-014 Each channel SHALL be an independent two-state FSM (IDLE, RUN) with a CNT_W-bit remaining counter plus latched mode and latched delay.
REQ-015 Effective delay D = count_i, except count_i == 0, which SHALL mean D = 2^CNT_W.
REQ-016 A start is accepted when start_i[c]=1 and abort_i[c]=0 in cycle N, and either the channel is IDLE or done_o[c] is high in cycle N while the channel is in one-shot mode.
REQ-017 On acceptance, the channel SHALL enter RUN from cycle N+1 and latch D and mode_i[c].
REQ-018 One-shot mode: done_o[c] SHALL be high in cycle N+D only. busy_o[c] SHALL be high in cycles N+1 .. N+D-1 and low from cycle N+D.
REQ-019 For D = 1, done_o[c] SHALL be high in cycle N+1 and busy_o[c] SHALL never assert.
REQ-020 Periodic mode: done_o[c] SHALL pulse in cycles N+D, N+2D, N+3D, ... The counter SHALL reload the latched D with no gap cycle. busy_o[c] SHALL stay high from N+1 until the cycle after abort.
REQ-021 Periodic mode with D = 1: done_o[c] SHALL be high in every cycle from N+1 until abort.
REQ-022 In periodic mode, start_i[c] SHALL be rejected even in a done_o cycle.
REQ-023 A start SHALL be rejected while the channel is busy, except as allowed by REQ-016. A rejected start SHALL pulse err_o[c] in the cycle after the rejected start and SHALL leave the running state untouched.
REQ-024 abort_i[c]=1 in cycle M while RUN: channel IDLE and busy_o[c]=0 from M+1. No done_o[c] SHALL occur in M+1 or later from that run. A done_o[c] already due in cycle M SHALL still be high.
REQ-025 abort_i[c] and start_i[c] high in the same cycle: abort SHALL win, the start SHALL be discarded, and err_o[c] SHALL NOT pulse.
REQ-026 abort_i[c] while IDLE SHALL have no effect.
REQ-027 Channels SHALL NOT interact. Simultaneous events on different channels SHALL each behave as if alone.
REQ-028 done_o, busy_o and err_o SHALL be driven from registers. any_done_o MAY be combinational from the done_o registers.
REQ-029 Counter arithmetic SHALL be CNT_W bits, modulo 2^CNT_W, with no overflow beyond the latched D.

Reset
REQ-030 While rst_n=0 at a rising edge, all channels SHALL go IDLE, and counters, latched D and latched mode SHALL clear to 0.
REQ-031 In the cycle after a reset edge, busy_o, done_o, err_o and any_done_o SHALL be 0.
REQ-032 A reset asserted mid-run SHALL cancel the run with no subsequent done_o.
REQ-033 Inputs SHALL be ignored during the cycles rst_n=0.

Verification
REQ-034 NUM_CH=4, CNT_W=4. Ch0 one-shot count=5 started in cycle 10 -> done_o[0] high in cycle 15 only. busy_o[0] high in cycles 11-14.
REQ-035 Ch1 one-shot count=0 started in cycle 0 -> done_o[1] high in cycle 16. Ch2 count=1 started in cycle 0 -> done_o[2] high in cycle 1 with busy_o[2] never high.
REQ-036 Ch0 periodic count=3 started in cycle 0, abort in cycle 7 -> done_o[0] high in cycles 3 and 6 only. busy_o[0] low from cycle 8.
REQ-037 Ch3 one-shot count=4 started in cycle 0. Start again in cycle 2 -> err_o[3] high in cycle 3 and done_o[3] high in cycle 4. Start in cycle 4 with count=2 -> accepted, done_o[3] high in cycle 6.
REQ-038 Ch0 and ch1 one-shot count=3 started in cycle 0, and rst_n=0 in cycle 1 -> no done_o on any channel. All outputs 0 from cycle 2.
REQ-039 Start and abort both high on an idle channel -> channel stays IDLE, with no err_o and no done_o.
